regfile_writeback_queue: RTL and testbench

- Producer side of the register file's single write port.
- Collects completed results from two sources, the ALU path and the memory/load path, into a small in-order queue.
- Drains the queue at one write per cycle onto the register file's we / writeRegister / writeData inputs.
- Exports a pending-write mask so hazard logic can stall readers of registers whose value is still in flight.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 98 +++++++++
 rtl/regfile_writeback_queue.sv | 134 +++++++++++++
 tb/tb_regfile_writeback_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the register-file write-back path.
//   ADDR_W     : register address width (32 registers)
//   DATA_W     : register data width
//   NUM_REGS   : number of architectural registers
//   wb_entry_t : one pending register write (destination address + data)
//   reg_onehot : one-hot decode of a register address, used for the pending mask
package mips_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32'd1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of pending register writes.
// Accepts up to two pushes per cycle (push0 lands ahead of push1) and at most
// one pop per cycle. The caller guarantees it never overfills or pops empty.
//   clk, reset             : clock, synchronous active-high reset
//   push0_valid/entry      : first (older) entry to append
//   push1_valid/entry      : second (younger) entry to append
//   pop                    : remove the head entry this cycle
//   head_entry             : current head of the queue
//   count                  : number of occupied entries (0..DEPTH)
//   entry_valid, slots     : per-physical-slot occupancy and contents
module wb_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push0_valid,
  input  wb_entry_t              push0_entry,
  input  logic                   push1_valid,
  input  wb_entry_t              push1_entry,
  input  logic                   pop,
  output wb_entry_t              head_entry,
  output logic [CW-1:0]          count,
  output logic [DEPTH-1:0]       entry_valid,
  output wb_entry_t [DEPTH-1:0]  slots
);

  localparam int AW = CW - 1;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [1:0]            push_n_s;
  logic [AW-1:0]         slot_b_s;

  // Next-state: storage writes, pointer advance and occupancy update
  always_comb begin
    mem_d    = mem_q;
    slot_b_s = wr_ptr_q + AW'(1);
    push_n_s = {1'b0, push0_valid} + {1'b0, push1_valid};
    if (push0_valid) begin
      mem_d[wr_ptr_q] = push0_entry;
      if (push1_valid) begin
        mem_d[slot_b_s] = push1_entry;
      end else begin
        mem_d[slot_b_s] = mem_q[slot_b_s];
      end
    end else if (push1_valid) begin
      // A lone younger push takes the first free slot.
      mem_d[wr_ptr_q] = push1_entry;
    end else begin
      mem_d = mem_q;
    end
    // Truncating the push count to AW bits keeps the pointer modulo DEPTH.
    wr_ptr_d = wr_ptr_q + AW'(push_n_s);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CW'(push_n_s) - CW'(pop);
  end

  // Occupancy per physical slot: a slot is live if its distance from the
  // read pointer is below the current count.
  always_comb begin
    logic [AW-1:0] offset;
    offset      = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = AW'(i) - rd_ptr_q;
      entry_valid[i] = ({1'b0, offset} < count_q);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign slots      = mem_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Producer side of the register file's single write port.
// Merges load results (mem) and ALU results into an in-order queue and drains
// it one write per cycle onto registered we / writeRegister / writeData.
//   clk, reset                       : clock, synchronous active-high reset
//   mem_valid/ready/addr/data        : load-result handshake
//   alu_valid/ready/addr/data        : ALU-result handshake
//   we, writeRegister, writeData     : registered register-file write port
//   pending                          : registers with a write still in flight
//   idle                             : queue empty and no write on the port
module regfile_writeback_queue
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   we,
  output logic [ADDR_W-1:0]      writeRegister,
  output logic [DATA_W-1:0]      writeData,
  output logic [2**ADDR_W-1:0]   pending,
  output logic                   idle
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t             mem_entry_s, alu_entry_s, head_s;
  wb_entry_t [DEPTH-1:0] slots_s;
  logic [DEPTH-1:0]      entry_valid_s;
  logic [CW-1:0]         count_s, free_s;
  logic                  mem_push_s, alu_push_s, pop_s;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [2**ADDR_W-1:0]  pending_s;

  // Credit is based only on the count at the start of the cycle, so a pop in
  // the same cycle never opens a slot. When both sources are valid the ALU
  // needs two free slots because the load claims the first one.
  always_comb begin
    free_s    = CW'(DEPTH) - count_s;
    mem_ready = (free_s != '0);
    if (mem_valid) begin
      alu_ready = (free_s >= CW'(2));
    end else begin
      alu_ready = (free_s != '0);
    end
  end

  // Writes to register 0 complete their handshake but are dropped here.
  always_comb begin
    mem_entry_s = '{addr: mem_addr, data: mem_data};
    alu_entry_s = '{addr: alu_addr, data: alu_data};
    mem_push_s  = mem_valid && mem_ready && (mem_addr != '0);
    alu_push_s  = alu_valid && alu_ready && (alu_addr != '0);
    pop_s       = (count_s != '0);
  end

  // Load entry is pushed first: it belongs to the older instruction.
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push0_valid (mem_push_s),
    .push0_entry (mem_entry_s),
    .push1_valid (alu_push_s),
    .push1_entry (alu_entry_s),
    .pop         (pop_s),
    .head_entry  (head_s),
    .count       (count_s),
    .entry_valid (entry_valid_s),
    .slots       (slots_s)
  );

  // Output stage: present the head for one cycle, otherwise hold address/data.
  always_comb begin
    we_d      = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (pop_s) begin
      we_d      = 1'b1;
      wr_reg_d  = head_s.addr;
      wr_data_d = head_s.data;
    end else begin
      we_d = 1'b0;
    end
  end

  // Output-stage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      we_q      <= we_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Pending mask covers every live queue slot plus the write on the port.
  always_comb begin
    pending_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid_s[i]) begin
        pending_s = pending_s | reg_onehot(slots_s[i].addr);
      end else begin
        pending_s = pending_s;
      end
    end
    if (we_q) begin
      pending_s = pending_s | reg_onehot(wr_reg_q);
    end else begin
      pending_s = pending_s;
    end
    pending_s[0] = 1'b0;
  end

  assign pending       = pending_s;
  assign we            = we_q;
  assign writeRegister = wr_reg_q;
  assign writeData     = wr_data_q;
  assign idle          = (count_s == '0) && !we_q;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: a driver keeps a queue-level model of the
// write-back path and logs every accepted write; a monitor on the falling edge
// retires logged writes against what the DUT presents.
module tb_regfile_writeback_queue;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0, alu_valid = 1'b0;
  logic [4:0]  mem_addr = 5'd0, alu_addr = 5'd0;
  logic [31:0] mem_data = 32'd0, alu_data = 32'd0;
  logic        mem_ready, alu_ready, we, idle;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [31:0] pending;

  regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .we(we), .writeRegister(writeRegister), .writeData(writeData),
    .pending(pending), .idle(idle)
  );

  always #5 clk = ~clk;

  // ---------------- driver-owned state ----------------
  wb_entry_t model_q[$];   // entries waiting in the queue (not yet on the port)
  wb_entry_t sb_q[$];      // every accepted write, in acceptance order
  bit        exp_we;
  bit        exp_mr, exp_ar;
  bit        acc_mem, acc_alu;   // handshakes that will land on the coming edge
  wb_entry_t acc_mem_e, acc_alu_e;
  bit        rst_pend = 1'b1;
  int        rst_epoch = 0;
  int        flush_to = 0;
  bit        mon_en = 1'b0;
  bit        last_mem_took, last_alu_took;
  int        probe_req = 0;
  int        probe_reg;
  logic [31:0] probe_val;
  bit        final_req = 1'b0;

  // ---------------- monitor-owned state ----------------
  int          checks = 0;
  int          failures = 0;
  int          rd_idx = 0;
  int          seen_epoch = 0;
  int          probe_ack = 0;
  bit          final_done = 1'b0;
  logic [4:0]  exp_last_a;
  logic [31:0] exp_last_d;
  logic [31:0] rf_dut [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: account for the edge just taken, then drive new inputs.
  task automatic step(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic rst);
    int free;
    @(posedge clk);
    #1;
    if (rst_pend) begin
      model_q.delete();
      exp_we   = 1'b0;
      flush_to = sb_q.size();
      rst_epoch++;
    end else begin
      if (model_q.size() > 0) begin
        void'(model_q.pop_front());
        exp_we = 1'b1;
      end else begin
        exp_we = 1'b0;
      end
      if (acc_mem) begin model_q.push_back(acc_mem_e); sb_q.push_back(acc_mem_e); end
      if (acc_alu) begin model_q.push_back(acc_alu_e); sb_q.push_back(acc_alu_e); end
    end
    reset = rst; mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    free   = DEPTH - model_q.size();
    exp_mr = (free >= 1);
    exp_ar = mv ? (free >= 2) : (free >= 1);
    last_mem_took = mv && exp_mr;
    last_alu_took = av && exp_ar;
    acc_mem   = last_mem_took && !rst && (ma != 5'd0);
    acc_alu   = last_alu_took && !rst && (aa != 5'd0);
    acc_mem_e = '{addr: ma, data: md};
    acc_alu_e = '{addr: aa, data: ad};
    rst_pend  = rst;
  endtask

  task automatic idle_step();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  // Monitor: compare the DUT against the logged writes on every falling edge.
  initial begin
    wb_entry_t e;
    logic [31:0] exp_pend;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst_epoch != seen_epoch) begin
          seen_epoch = rst_epoch;
          rd_idx     = flush_to;
          exp_last_a = 5'd0;
          exp_last_d = 32'd0;
        end
        chk("mem_ready", 64'(mem_ready), 64'(exp_mr));
        chk("alu_ready", 64'(alu_ready), 64'(exp_ar));
        chk("we", 64'(we), 64'(exp_we));
        exp_pend = 32'd0;
        for (int i = rd_idx; i < sb_q.size(); i++) exp_pend[sb_q[i].addr] = 1'b1;
        chk("pending", 64'(pending), 64'(exp_pend));
        chk("idle", 64'(idle), 64'(rd_idx == sb_q.size()));
        if (we === 1'b1) begin
          if (rd_idx >= sb_q.size()) begin
            chk("unexpected_write", 64'(writeRegister), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = sb_q[rd_idx];
            rd_idx++;
            chk("write_addr", 64'(writeRegister), 64'(e.addr));
            chk("write_data", 64'(writeData), 64'(e.data));
            exp_last_a = e.addr;
            exp_last_d = e.data;
            rf_dut[writeRegister] = writeData;
          end
        end else begin
          chk("hold_addr", 64'(writeRegister), 64'(exp_last_a));
          chk("hold_data", 64'(writeData), 64'(exp_last_d));
        end
        if (probe_req != probe_ack) begin
          probe_ack = probe_req;
          chk("rf_probe", 64'(rf_dut[probe_reg]), 64'(probe_val));
        end
        if (final_req && !final_done) begin
          chk("drain_empty", 64'(sb_q.size() - rd_idx), 64'd0);
          final_done = 1'b1;
        end
      end
    end
  end

  initial begin
    logic        mv, av;
    logic [4:0]  ma, aa;
    logic [31:0] md, ad;
    int          guard;

    // Reset is high at the first edge; release it and start checking.
    idle_step();
    mon_en = 1'b1;
    idle_step();

    // Single ALU write r5 = DEADBEEF.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    repeat (3) idle_step();
    probe_reg = 5; probe_val = 32'hDEAD_BEEF; probe_req++;
    idle_step();

    // Dual accept from empty: r4 (load) must retire before r3 (ALU).
    step(1'b1, 5'd4, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0);
    repeat (3) idle_step();
    probe_reg = 4; probe_val = 32'h11; probe_req++;
    idle_step();

    // Both sources valid every cycle; refused sources hold their request.
    mv = 1'b0; av = 1'b0; ma = 5'd0; aa = 5'd0; md = 32'd0; ad = 32'd0;
    last_mem_took = 1'b1; last_alu_took = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (!mv || last_mem_took) begin ma = 5'($urandom_range(1, 31)); md = $urandom; end
      if (!av || last_alu_took) begin aa = 5'($urandom_range(1, 31)); ad = $urandom; end
      mv = 1'b1; av = 1'b1;
      step(mv, ma, md, av, aa, ad, 1'b0);
    end
    repeat (5) idle_step();

    // ALU write to r0: accepted, never written, never pending.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    repeat (3) idle_step();

    // Queue three entries, then reset: none of the queued writes may appear.
    step(1'b1, 5'd7, 32'h7777, 1'b1, 5'd8, 32'h8888, 1'b0);
    step(1'b1, 5'd9, 32'h9999, 1'b1, 5'd10, 32'hAAAA, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    repeat (4) idle_step();

    // Randomised traffic with source hold and occasional reset.
    mv = 1'b0; av = 1'b0;
    last_mem_took = 1'b1; last_alu_took = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (($urandom % 64) == 0) begin
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        mv = 1'b0; av = 1'b0;
        last_mem_took = 1'b1; last_alu_took = 1'b1;
      end else begin
        if (!mv || last_mem_took) begin
          mv = ($urandom % 3) != 0;
          ma = 5'($urandom_range(0, 31)); md = $urandom;
        end
        if (!av || last_alu_took) begin
          av = ($urandom % 3) != 0;
          aa = 5'($urandom_range(0, 31)); ad = $urandom;
        end
        step(mv, ma, md, av, aa, ad, 1'b0);
      end
    end

    // Drain with a bounded wait, then ask the monitor for the final check.
    guard = 0;
    while ((rd_idx != sb_q.size() || guard < 2) && guard < 40) begin
      idle_step();
      guard++;
    end
    final_req = 1'b1;
    idle_step();
    idle_step();
    if (!final_done) begin
      $display("FAIL final_check actual=not_run required=run");
      $fatal(1, "monitor did not complete final check");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
